// File: rtl/player_input_checker_pkg.sv
// Shared definitions for the player input checker: direction codes,
// FSM state encoding and small key-decoding helpers.
package player_input_checker_pkg;

  // Direction codes, identical to the playback stage's arrow encoding.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_PRESS   = 3'd1,
    S_WAIT_RELEASE = 3'd2,
    S_PASS         = 3'd3,
    S_FAIL         = 3'd4
  } state_t;

  // Number of buttons currently held.
  function automatic logic [2:0] key_count(input logic [3:0] keys);
    return {2'b00, keys[0]} + {2'b00, keys[1]} + {2'b00, keys[2]} + {2'b00, keys[3]};
  endfunction

  // Direction of the highest held button; only meaningful when exactly one is held.
  function automatic logic [1:0] key_dir(input logic [3:0] keys);
    logic [1:0] d;
    if (keys[3]) begin
      d = DIR_RIGHT;
    end else if (keys[2]) begin
      d = DIR_LEFT;
    end else if (keys[1]) begin
      d = DIR_DOWN;
    end else begin
      d = DIR_UP;
    end
    return d;
  endfunction

endpackage

// File: rtl/player_input_checker_key_press_encoder.sv
// Turns the debounced key vector into a rising-press event, a single-key
// flag and the encoded direction. Only keys_prev is stateful.
module key_press_encoder
  import player_input_checker_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keys,
  output logic       press_evt,
  output logic       one_hot_ok,
  output logic [1:0] dir
);

  logic [3:0] keys_prev;

  // Remember last cycle's keys so a press is seen only when coming from all-released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keys_prev <= 4'b0000;
    end else begin
      keys_prev <= keys;
    end
  end

  assign press_evt  = (keys != 4'b0000) && (keys_prev == 4'b0000);
  assign one_hot_ok = (key_count(keys) == 3'd1);
  assign dir        = key_dir(keys);

endmodule

// File: rtl/player_input_checker.sv
// Checks the player's arrow presses against the latched move sequence,
// one move per press, with a per-press timeout. Outputs are registered.
module player_input_checker
  import player_input_checker_pkg::*;
#(
  parameter int NUM_MOVES   = 4,
  parameter int TIMEOUT_CYC = 250000000,
  parameter int TO_W        = 28,
  localparam int SEQ_W      = 2 * NUM_MOVES,
  localparam int MD_W       = $clog2(NUM_MOVES + 1),
  localparam int IDX_W      = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [SEQ_W-1:0] move_seq,
  input  logic [3:0]       keys,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [MD_W-1:0]  moves_done,
  output logic [1:0]       last_dir
);

  state_t            state_r, state_next;
  logic [SEQ_W-1:0]  seq_r, seq_next;
  logic [IDX_W-1:0]  idx_r, idx_next;
  logic [MD_W-1:0]   md_next;
  logic [TO_W-1:0]   timer_r, timer_next;
  logic [1:0]        last_next;
  logic [1:0]        cur_move;
  logic              press_evt, one_hot_ok;
  logic [1:0]        dir;

  key_press_encoder u_enc (
    .clock      (clock),
    .reset      (reset),
    .keys       (keys),
    .press_evt  (press_evt),
    .one_hot_ok (one_hot_ok),
    .dir        (dir)
  );

  assign cur_move = seq_r[{idx_r, 1'b0} +: 2];

  // Next-state logic; start overrides every other transition.
  always_comb begin
    state_next = state_r;
    seq_next   = seq_r;
    idx_next   = idx_r;
    md_next    = moves_done;
    timer_next = timer_r;
    last_next  = last_dir;
    if (start) begin
      seq_next   = move_seq;
      idx_next   = {IDX_W{1'b0}};
      md_next    = {MD_W{1'b0}};
      timer_next = {TO_W{1'b0}};
      state_next = S_WAIT_PRESS;
    end else begin
      case (state_r)
        S_WAIT_PRESS: begin
          if (press_evt) begin
            if (!one_hot_ok) begin
              state_next = S_FAIL;
            end else if (dir != cur_move) begin
              last_next  = dir;
              state_next = S_FAIL;
            end else begin
              last_next  = dir;
              md_next    = (moves_done == MD_W'(NUM_MOVES)) ? moves_done : moves_done + MD_W'(1);
              idx_next   = (idx_r == IDX_W'(NUM_MOVES - 1)) ? idx_r : idx_r + IDX_W'(1);
              timer_next = {TO_W{1'b0}};
              state_next = S_WAIT_RELEASE;
            end
          end else if (timer_r == TO_W'(TIMEOUT_CYC - 1)) begin
            state_next = S_FAIL;
          end else begin
            timer_next = timer_r + TO_W'(1);
          end
        end
        S_WAIT_RELEASE: begin
          timer_next = {TO_W{1'b0}};
          if (keys == 4'b0000) begin
            state_next = (moves_done == MD_W'(NUM_MOVES)) ? S_PASS : S_WAIT_PRESS;
          end else begin
            state_next = S_WAIT_RELEASE;
          end
        end
        default: begin
          state_next = state_r;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      seq_r      <= {SEQ_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      moves_done <= {MD_W{1'b0}};
      timer_r    <= {TO_W{1'b0}};
      last_dir   <= 2'b00;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_r    <= state_next;
      seq_r      <= seq_next;
      idx_r      <= idx_next;
      moves_done <= md_next;
      timer_r    <= timer_next;
      last_dir   <= last_next;
      busy       <= (state_next == S_WAIT_PRESS) || (state_next == S_WAIT_RELEASE);
      pass       <= (state_next == S_PASS);
      fail       <= (state_next == S_FAIL);
    end
  end

endmodule

// File: tb/tb_player_input_checker.sv
// Randomized and directed bench for player_input_checker, compared every
// cycle against a behavioural model of the round rules.
module tb_player_input_checker;

  localparam int NM = 4;
  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] move_seq = 8'h00;
  logic [3:0] keys = 4'b0000;
  logic       busy, pass, fail;
  logic [2:0] moves_done;
  logic [1:0] last_dir;

  int n_checks = 0;
  int n_errors = 0;

  // model of the round
  int m_moves[NM];
  int m_done, m_timer, m_last;
  bit m_busy, m_hold, m_pass, m_fail;
  logic [3:0] m_prev;

  player_input_checker #(.NUM_MOVES(NM), .TIMEOUT_CYC(TO), .TO_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .move_seq(move_seq), .keys(keys),
    .busy(busy), .pass(pass), .fail(fail), .moves_done(moves_done), .last_dir(last_dir)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_done = 0; m_timer = 0; m_last = 0;
    m_busy = 0; m_hold = 0; m_pass = 0; m_fail = 0; m_prev = 4'b0000;
  endtask

  task automatic model_fail();
    m_busy = 0; m_hold = 0; m_fail = 1;
  endtask

  // One clock of the game rules, applied to the inputs sampled at the edge.
  task automatic model_step(input logic [3:0] k, input logic s, input logic [7:0] sq);
    bit press;
    int d;
    press = (k != 4'b0000) && (m_prev == 4'b0000);
    if (s) begin
      for (int i = 0; i < NM; i++) m_moves[i] = (sq >> (2 * i)) & 3;
      m_done = 0; m_timer = 0; m_busy = 1; m_hold = 0; m_pass = 0; m_fail = 0;
    end else if (m_busy && !m_hold) begin
      if (press) begin
        if ($countones(k) != 1) begin
          model_fail();
        end else begin
          d = 0;
          for (int i = 0; i < 4; i++) if (k[i]) d = i;
          m_last = d;
          if (d == m_moves[m_done]) begin
            m_done++; m_hold = 1; m_timer = 0;
          end else begin
            model_fail();
          end
        end
      end else if (m_timer == TO - 1) begin
        model_fail();
      end else begin
        m_timer++;
      end
    end else if (m_busy && m_hold) begin
      if (k == 4'b0000) begin
        m_hold = 0;
        if (m_done == NM) begin
          m_busy = 0; m_pass = 1;
        end
      end
    end
    m_prev = k;
  endtask

  task automatic compare_all();
    check_val("busy", int'(busy), int'(m_busy));
    check_val("pass", int'(pass), int'(m_pass));
    check_val("fail", int'(fail), int'(m_fail));
    check_val("moves_done", int'(moves_done), m_done);
    check_val("last_dir", int'(last_dir), m_last);
  endtask

  // Drive one cycle of inputs after a falling edge, then check after the next falling edge.
  task automatic tick(input logic [3:0] k, input logic s, input logic [7:0] sq);
    keys = k; start = s; move_seq = sq;
    @(posedge clock);
    model_step(k, s, sq);
    @(negedge clock);
    compare_all();
  endtask

  task automatic press_release(input int d, input int hold, input int gap);
    for (int i = 0; i < hold; i++) tick(4'b0001 << d, 1'b0, 8'h00);
    for (int i = 0; i < gap; i++) tick(4'b0000, 1'b0, 8'h00);
  endtask

  logic [3:0] kn, kc;
  logic [7:0] sv;
  int r;

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
    check_val("reset_busy", int'(busy), 0);

    // 1: full pass
    tick(4'b0000, 1'b1, 8'b11_10_01_00);
    for (int d = 0; d < 4; d++) press_release(d, 3, 2);
    check_val("t1_pass", int'(pass), 1);
    check_val("t1_fail", int'(fail), 0);
    check_val("t1_md", int'(moves_done), 4);
    check_val("t1_busy", int'(busy), 0);

    // 2: mismatch
    tick(4'b0000, 1'b1, 8'b11_10_01_00);
    press_release(0, 2, 2);
    tick(4'b0100, 1'b0, 8'h00);
    check_val("t2_fail", int'(fail), 1);
    check_val("t2_md", int'(moves_done), 1);
    check_val("t2_last", int'(last_dir), 2);
    tick(4'b0000, 1'b0, 8'h00);

    // 3: timeout, then a press exactly at the last allowed cycle
    tick(4'b0000, 1'b1, 8'b11_10_01_00);
    for (int i = 0; i < TO - 1; i++) tick(4'b0000, 1'b0, 8'h00);
    check_val("t3_not_yet", int'(fail), 0);
    tick(4'b0000, 1'b0, 8'h00);
    check_val("t3_fail", int'(fail), 1);
    check_val("t3_busy", int'(busy), 0);
    tick(4'b0000, 1'b1, 8'b11_10_01_00);
    for (int i = 0; i < TO - 1; i++) tick(4'b0000, 1'b0, 8'h00);
    tick(4'b0001, 1'b0, 8'h00);
    check_val("t3_late_press_md", int'(moves_done), 1);
    check_val("t3_late_press_fail", int'(fail), 0);
    tick(4'b0000, 1'b0, 8'h00);

    // 4: multi-key press, then extra key while holding
    tick(4'b0000, 1'b1, 8'b11_10_01_00);
    tick(4'b0011, 1'b0, 8'h00);
    check_val("t4_multi_fail", int'(fail), 1);
    check_val("t4_multi_md", int'(moves_done), 0);
    tick(4'b0000, 1'b1, 8'b11_10_01_00);
    tick(4'b0001, 1'b0, 8'h00);
    tick(4'b1001, 1'b0, 8'h00);
    tick(4'b1001, 1'b0, 8'h00);
    tick(4'b0000, 1'b0, 8'h00);
    check_val("t4_hold_fail", int'(fail), 0);
    check_val("t4_hold_md", int'(moves_done), 1);

    // 5: restart mid-check, then asynchronous reset
    tick(4'b0000, 1'b1, 8'b11_10_01_00);
    press_release(0, 2, 2);
    press_release(1, 2, 2);
    check_val("t5_md2", int'(moves_done), 2);
    tick(4'b0000, 1'b1, 8'b11_10_01_00);
    check_val("t5_restart_md", int'(moves_done), 0);
    check_val("t5_restart_busy", int'(busy), 1);
    press_release(0, 1, 0);
    #2 reset = 1'b1;
    #1;
    check_val("t5_rst_busy", int'(busy), 0);
    check_val("t5_rst_md", int'(moves_done), 0);
    check_val("t5_rst_last", int'(last_dir), 0);
    check_val("t5_rst_passfail", int'({pass, fail}), 0);
    keys = 4'b0000; start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    compare_all();

    // 6: key held across start
    tick(4'b0001, 1'b1, 8'b11_10_01_00);
    tick(4'b0001, 1'b0, 8'h00);
    tick(4'b0001, 1'b0, 8'h00);
    check_val("t6_held_md", int'(moves_done), 0);
    tick(4'b0000, 1'b0, 8'h00);
    tick(4'b0001, 1'b0, 8'h00);
    check_val("t6_repress_md", int'(moves_done), 1);
    tick(4'b0000, 1'b0, 8'h00);

    // Random rounds; move_seq wanders between starts and must be ignored.
    for (int ep = 0; ep < 60; ep++) begin
      sv = 8'($urandom);
      tick(4'b0000, 1'b1, sv);
      kc = 4'b0000;
      for (int c = 0; c < 120; c++) begin
        r = $urandom_range(0, 99);
        if (kc != 4'b0000) begin
          if (r < 40) kn = 4'b0000;
          else if (r < 46) kn = kc | (4'b0001 << $urandom_range(0, 3));
          else kn = kc;
        end else begin
          if (r < 50) kn = 4'b0000;
          else if (r < 88) kn = (m_done < NM) ? (4'b0001 << m_moves[m_done]) : 4'b0001;
          else if (r < 94) kn = 4'b0001 << $urandom_range(0, 3);
          else kn = 4'($urandom_range(1, 15));
        end
        kc = kn;
        tick(kn, ($urandom_range(0, 199) == 0), 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
